// File: rtl/led_adc_sequencer_pkg.sv
// Shared definitions for the LED/ADC operation-mode sequencer.
//   - AFE field widths (DC compensation, PGA gain, ADC sample)
//   - DC compensation reset code (mid-scale)
//   - FSM state and channel encodings, per-channel AFE setting struct
package led_adc_sequencer_pkg;

  localparam int DC_W  = 7;
  localparam int PGA_W = 4;
  localparam int ADC_W = 8;

  localparam logic [DC_W-1:0] DC_COMP_RESET = 7'd64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_GAP
  } state_t;

  typedef enum logic {
    CH_RED = 1'b0,
    CH_IR  = 1'b1
  } ch_t;

  typedef struct packed {
    logic [DC_W-1:0]  dc;
    logic [PGA_W-1:0] pga;
  } afe_cfg_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_adc_sequencer_sample_averager.sv
// Block averager for one channel's sample window.
//   CLK, rst_n : clock, async active-low reset
//   clr        : zero the accumulator (asserted on the cycle before the window)
//   acc_en     : add adc into the accumulator this cycle
//   adc        : unsigned ADC sample
//   avg        : accumulator >> LOG2_SAMPLES (truncating)
// The accumulator is ADC_W+LOG2_SAMPLES wide, so 2^LOG2_SAMPLES full-scale
// samples cannot overflow it.
module sample_averager
  import led_adc_sequencer_pkg::*;
#(
  parameter int LOG2_SAMPLES = 4
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             acc_en,
  input  logic [ADC_W-1:0] adc,
  output logic [ADC_W-1:0] avg
);

  localparam int ACC_W = ADC_W + LOG2_SAMPLES;

  logic [ACC_W-1:0] acc;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (clr)    acc <= '0;
    else if (acc_en) acc <= acc + ACC_W'(adc);
  end

  assign avg = acc[LOG2_SAMPLES +: ADC_W];

endmodule

// File: rtl/led_adc_sequencer.sv
// Operation-mode scheduler for the shared pulse-oximeter AFE.
// Alternates the single ADC path between RED and IR: applies the channel's
// latched DC_Comp/PGA setting, lights its LED, waits SETTLE_CYCLES, averages
// 2^LOG2_SAMPLES ADC samples, then holds both LEDs off for GAP_CYCLES while
// publishing the averaged value with a one-cycle valid strobe.
// Ports:
//   CLK, rst_n                   : clock, async active-low reset
//   enable                       : run request, looked at in IDLE and at frame end
//   red_dc_comp/red_pga          : RED setting (latched at frame start)
//   ir_dc_comp/ir_pga            : IR setting (latched at frame start)
//   ADC                          : unsigned 8-bit sample
//   LED_RED, LED_IR              : LED drives (never both high)
//   DC_Comp, PGA_Gain            : AFE setting for the active channel
//   RED_ADC_Value, IR_ADC_Value  : latest averaged samples
//   red_valid, ir_valid          : one-cycle update strobes
//   busy                         : high whenever not IDLE
// All outputs are registered from the current state, so they lag the state
// register by one cycle.
module led_adc_sequencer
  import led_adc_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES = 20,
  parameter int LOG2_SAMPLES  = 4,
  parameter int GAP_CYCLES    = 4
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DC_W-1:0]  red_dc_comp,
  input  logic [PGA_W-1:0] red_pga,
  input  logic [DC_W-1:0]  ir_dc_comp,
  input  logic [PGA_W-1:0] ir_pga,
  input  logic [ADC_W-1:0] ADC,
  output logic             LED_RED,
  output logic             LED_IR,
  output logic [DC_W-1:0]  DC_Comp,
  output logic [PGA_W-1:0] PGA_Gain,
  output logic [ADC_W-1:0] RED_ADC_Value,
  output logic [ADC_W-1:0] IR_ADC_Value,
  output logic             red_valid,
  output logic             ir_valid,
  output logic             busy
);

  localparam int NSAMP   = 1 << LOG2_SAMPLES;
  localparam int CNT_MAX = max3(SETTLE_CYCLES, NSAMP, GAP_CYCLES);
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t          state, state_nx;
  ch_t             ch, ch_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  afe_cfg_t [1:0]  shadow;
  logic            latch, clr, acc_en;
  logic [ADC_W-1:0] avg;

  logic             led_red_nx, led_ir_nx;
  logic [DC_W-1:0]  dc_nx;
  logic [PGA_W-1:0] pga_nx;
  logic [ADC_W-1:0] red_val_nx, ir_val_nx;
  logic             red_vld_nx, ir_vld_nx, busy_nx;

  sample_averager #(.LOG2_SAMPLES(LOG2_SAMPLES)) u_avg (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .clr    (clr),
    .acc_en (acc_en),
    .adc    (ADC),
    .avg    (avg)
  );

  // Next state, counter and datapath controls.
  always_comb begin
    state_nx = state;
    ch_nx    = ch;
    cnt_nx   = cnt + CW'(1);
    latch    = 1'b0;
    clr      = 1'b0;
    acc_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (enable) begin
          state_nx = ST_SETTLE;
          ch_nx    = CH_RED;
          latch    = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          state_nx = ST_SAMPLE;
          cnt_nx   = '0;
          clr      = 1'b1;   // accumulator is zero on the first SAMPLE cycle
        end
      end
      ST_SAMPLE: begin
        acc_en = 1'b1;
        if (cnt == CW'(NSAMP - 1)) begin
          state_nx = ST_GAP;
          cnt_nx   = '0;
        end
      end
      ST_GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_nx = '0;
          if (ch == CH_RED) begin
            state_nx = ST_SETTLE;
            ch_nx    = CH_IR;
          end else if (enable) begin
            // back-to-back frame, fresh setting latch, no IDLE bubble
            state_nx = ST_SETTLE;
            ch_nx    = CH_RED;
            latch    = 1'b1;
          end else begin
            state_nx = ST_IDLE;
            ch_nx    = CH_RED;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the current state.
  always_comb begin
    led_red_nx = 1'b0;
    led_ir_nx  = 1'b0;
    dc_nx      = DC_Comp;
    pga_nx     = PGA_Gain;
    red_val_nx = RED_ADC_Value;
    ir_val_nx  = IR_ADC_Value;
    red_vld_nx = 1'b0;
    ir_vld_nx  = 1'b0;
    busy_nx    = (state != ST_IDLE);
    if (state == ST_SETTLE || state == ST_SAMPLE) begin
      led_red_nx = (ch == CH_RED);
      led_ir_nx  = (ch == CH_IR);
      dc_nx      = shadow[ch].dc;
      pga_nx     = shadow[ch].pga;
    end
    // First GAP cycle: the accumulator holds the complete window.
    if (state == ST_GAP && cnt == '0) begin
      if (ch == CH_RED) begin
        red_val_nx = avg;
        red_vld_nx = 1'b1;
      end else begin
        ir_val_nx  = avg;
        ir_vld_nx  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ch            <= CH_RED;
      cnt           <= '0;
      shadow        <= '0;
      LED_RED       <= 1'b0;
      LED_IR        <= 1'b0;
      DC_Comp       <= DC_COMP_RESET;
      PGA_Gain      <= '0;
      RED_ADC_Value <= '0;
      IR_ADC_Value  <= '0;
      red_valid     <= 1'b0;
      ir_valid      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      ch            <= ch_nx;
      cnt           <= cnt_nx;
      if (latch) begin
        shadow[CH_RED] <= '{dc: red_dc_comp, pga: red_pga};
        shadow[CH_IR]  <= '{dc: ir_dc_comp,  pga: ir_pga};
      end
      LED_RED       <= led_red_nx;
      LED_IR        <= led_ir_nx;
      DC_Comp       <= dc_nx;
      PGA_Gain      <= pga_nx;
      RED_ADC_Value <= red_val_nx;
      IR_ADC_Value  <= ir_val_nx;
      red_valid     <= red_vld_nx;
      ir_valid      <= ir_vld_nx;
      busy          <= busy_nx;
    end
  end

endmodule

// File: doc/led_adc_sequencer.md
# led_adc_sequencer

Operation-mode scheduler for the shared pulse-oximeter analog front end (LED driver, DC compensation DAC, PGA, 8-bit ADC). It time-multiplexes the single ADC path between the RED and IR channels: applies each channel's stored DC_Comp/PGA setting, lights the matching LED, waits out analog settling, averages a block of ADC samples, and publishes one value per channel per frame. It sits downstream of the setting-search controller, which supplies the per-channel settings.

## Interface

- SETTLE_CYCLES, 20: cycles after LED/setting switch during which ADC is ignored; legal range ≥1.
- LOG2_SAMPLES, 4: log2 of samples averaged per channel per frame (N = 2^LOG2_SAMPLES); legal range 0..5.
- GAP_CYCLES, 4: both-LEDs-off cycles after each channel's sample window; legal range ≥1.

- CLK  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request; sampled only in IDLE and at frame end.
- red_dc_comp  in  7  RED DC compensation code.
- red_pga  in  4  RED PGA gain code.
- ir_dc_comp  in  7  IR DC compensation code.
- ir_pga  in  4  IR PGA gain code.
- ADC  in  8  ADC sample, unsigned.
- LED_RED  out  1  RED LED on.
- LED_IR  out  1  IR LED on.
- DC_Comp  out  7  DC compensation code to the AFE.
- PGA_Gain  out  4  PGA gain code to the AFE.
- RED_ADC_Value  out  8  latest averaged RED sample.
- IR_ADC_Value  out  8  latest averaged IR sample.
- red_valid  out  1  one-cycle strobe: RED_ADC_Value updated.
- ir_valid  out  1  one-cycle strobe: IR_ADC_Value updated.
- busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE, SETTLE, SAMPLE, GAP; a channel bit (RED=0, IR=1) qualifies SETTLE/SAMPLE/GAP.
- IDLE: LEDs off, busy=0. enable=1 → SETTLE(RED); all four config inputs latched into shadow registers in that same transition.
- SETTLE(ch): LED of ch on, other off; DC_Comp/PGA_Gain driven from ch's shadow values; counter runs SETTLE_CYCLES cycles, ADC ignored → SAMPLE(ch).
- SAMPLE(ch): ADC accumulated every cycle for N cycles; accumulator width 8+LOG2_SAMPLES, cleared on SAMPLE entry, no overflow possible → GAP(ch).
- GAP entry: result = accumulator >> LOG2_SAMPLES (truncating) written to the ch value register; ch valid strobe high for that first GAP cycle; both LEDs off; DC_Comp/PGA_Gain hold.
- GAP(RED) end → SETTLE(IR). GAP(IR) end = frame end: enable=1 → SETTLE(RED) with fresh config latch; enable=0 → IDLE.
- enable dropping mid-frame has no effect until frame end; the frame always completes both channels.
- Config inputs changing mid-frame are ignored until the next latch.
- LED_RED and LED_IR are never high simultaneously.

## Timing

- Reset values: LED_RED=0, LED_IR=0, DC_Comp=7'd64, PGA_Gain=0, RED_ADC_Value=0, IR_ADC_Value=0, red_valid=0, ir_valid=0, busy=0; state IDLE, counters and accumulator 0.
- All outputs registered. enable seen high in IDLE at edge t0 → edge t0+1: LED_RED=1, DC_Comp/PGA_Gain = RED settings, busy=1.
- RED samples taken at edges t0+SETTLE_CYCLES+1 … t0+SETTLE_CYCLES+N; red_valid and new RED_ADC_Value at t0+SETTLE_CYCLES+N+1.
- Channel slot = SETTLE_CYCLES+N+GAP_CYCLES cycles; frame = 2× slot; IR timing identical, offset by one slot.
- Back-to-back frames: no extra IDLE cycle between GAP(IR) and SETTLE(RED).
- rst_n asserted anytime, including mid-SAMPLE: all outputs to reset values immediately (asynchronous); partial accumulation discarded; after release, restart only via enable in IDLE.

## Structure

- Shared package: state enum, channel encoding, DC_COMP_RESET (7'd64), field widths (DC 7, PGA 4, ADC 8).
- One sub-module: sample_averager (clear, accumulate-enable, ADC in, averaged result out; parameter LOG2_SAMPLES).

## Test plan

Parameters SETTLE_CYCLES=4, LOG2_SAMPLES=2, GAP_CYCLES=2 (slot 10, frame 20).
- Constant ADC=200, red_dc_comp=50, red_pga=3, enable held → at t0+1 LED_RED=1, DC_Comp=50, PGA_Gain=3; at t0+9 red_valid=1, RED_ADC_Value=200; at t0+19 ir_valid=1.
- ADC 10,20,30,40 during RED samples, 255 during IR samples → RED_ADC_Value=25, IR_ADC_Value=255; ADC values during SETTLE (e.g. 0) do not affect results.
- enable pulsed one cycle → exactly one full frame (one red_valid, one ir_valid), then IDLE with busy=0, LEDs off.
- red_dc_comp changed 50→90 at t0+5 → DC_Comp stays 50 in frame 1, becomes 90 at t0+21.
- rst_n asserted at t0+7 (mid-SAMPLE) → LEDs off, DC_Comp=64, values 0, no valid strobe; after release with enable=0, remains IDLE.
- Assert LED_RED & LED_IR never both 1 over 10 random-config frames.
